// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-mode LED pattern generator with programmable step prescaler
module led_pattern_gen #(
  parameter int N_LEDS    = 4,
  parameter int NB_COUNT  = 32,
  parameter int NB_SEL    = 2,
  parameter int BASE_LOG2 = 22
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [NB_SEL-1:0] i_speed,
  input  logic [1:0]        i_mode,
  input  logic              i_color,
  output logic [N_LEDS-1:0] o_led,
  output logic [N_LEDS-1:0] o_led_b,
  output logic [N_LEDS-1:0] o_led_g,
  output logic              o_step
);

  typedef enum logic [1:0] {
    MODE_ROTL  = 2'd0,
    MODE_ROTR  = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [N_LEDS-1:0] ONE_HOT_INIT = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] ALL_ON       = '1;

  logic [NB_COUNT-1:0] counter;
  logic [N_LEDS-1:0]   pattern;
  dir_t                dir;
  mode_t               mode_q;
  logic                step;

  logic [NB_COUNT:0]   limit_pow;
  logic [NB_COUNT-1:0] limit;
  logic                tick;
  logic                reload;
  logic [N_LEDS-1:0]   next_pattern;
  dir_t                next_dir;

  // One extra bit lets the top speed reach an all-ones limit of the full counter width.
  always_comb begin
    limit_pow = (NB_COUNT + 1)'(1) << (BASE_LOG2 + int'(i_speed));
    limit     = limit_pow[NB_COUNT-1:0] - NB_COUNT'(1);
  end

  assign reload = (mode_t'(i_mode) != mode_q);
  assign tick   = i_enable && (counter >= limit);

  always_comb begin
    next_pattern = pattern;
    next_dir     = dir;
    case (mode_q)
      MODE_ROTL:  next_pattern = (pattern << 1) | (pattern >> (N_LEDS - 1));
      MODE_ROTR:  next_pattern = (pattern >> 1) | (pattern << (N_LEDS - 1));
      MODE_PING: begin
        // A single LED has nowhere to bounce to, so it simply stays lit.
        if (N_LEDS > 1) begin
          if (dir == DIR_UP) begin
            if (pattern[N_LEDS-1]) begin
              next_pattern = pattern >> 1;
              next_dir     = DIR_DOWN;
            end else begin
              next_pattern = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              next_pattern = pattern << 1;
              next_dir     = DIR_UP;
            end else begin
              next_pattern = pattern >> 1;
            end
          end
        end
      end
      MODE_BLINK: next_pattern = ~pattern;
      default:    next_pattern = pattern;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter <= '0;
      pattern <= ONE_HOT_INIT;
      dir     <= DIR_UP;
      mode_q  <= MODE_ROTL;
      step    <= 1'b0;
    end else begin
      mode_q <= mode_t'(i_mode);
      // Mode reload wins over a coincident tick so a new mode always starts clean.
      if (reload) begin
        counter <= '0;
        dir     <= DIR_UP;
        step    <= 1'b0;
        pattern <= (mode_t'(i_mode) == MODE_BLINK) ? ALL_ON : ONE_HOT_INIT;
      end else if (tick) begin
        counter <= '0;
        pattern <= next_pattern;
        dir     <= next_dir;
        step    <= 1'b1;
      end else begin
        step <= 1'b0;
        if (i_enable) begin
          counter <= counter + NB_COUNT'(1);
        end
      end
    end
  end

  assign o_led   = pattern;
  assign o_led_b = i_color ? '0 : pattern;
  assign o_led_g = i_color ? pattern : '0;
  assign o_step  = step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [1:0] speed;
  logic [1:0] mode;
  logic       color;
  logic [3:0] led;
  logic [3:0] led_b;
  logic [3:0] led_g;
  logic       step;

  int checks;
  int failures;

  led_pattern_gen #(
    .N_LEDS(4), .NB_COUNT(8), .NB_SEL(2), .BASE_LOG2(2)
  ) dut (
    .clock(clock), .reset(reset), .i_enable(enable), .i_speed(speed),
    .i_mode(mode), .i_color(color), .o_led(led), .o_led_b(led_b),
    .o_led_g(led_g), .o_step(step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [1:0] spd;
    logic [1:0] md;
    logic       col;
    int         cyc;
    logic [3:0] exp_led;
    logic       exp_step;
  } vec_t;

  vec_t vecs[$];

  // Reference model: position/phase counters rather than shift registers.
  int m_cnt;
  int m_idx;
  int m_phase;
  bit m_on;
  int m_mode;
  bit m_step;

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_phase = 0; m_on = 1'b0; m_mode = 0; m_step = 1'b0;
  endtask

  task automatic model_step();
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_cnt = 0; m_idx = 0; m_phase = 0; m_on = 1'b1; m_step = 1'b0;
    end else if (enable && m_cnt >= (1 << (2 + int'(speed))) - 1) begin
      m_cnt = 0;
      m_step = 1'b1;
      case (m_mode)
        0: m_idx = (m_idx + 1) % 4;
        1: m_idx = (m_idx + 3) % 4;
        2: m_phase = (m_phase + 1) % 6;
        default: m_on = !m_on;
      endcase
    end else begin
      if (enable) m_cnt++;
      m_step = 1'b0;
    end
  endtask

  function automatic logic [3:0] model_led();
    int pos;
    if (m_mode == 3) return m_on ? 4'hF : 4'h0;
    if (m_mode == 2) begin
      pos = (m_phase < 4) ? m_phase : 6 - m_phase;
      return 4'(1 << pos);
    end
    return 4'(1 << m_idx);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] exp_led, input logic exp_step);
    check({name, "_led"}, 32'(led), 32'(exp_led));
    check({name, "_b"}, 32'(led_b), color ? 32'(0) : 32'(exp_led));
    check({name, "_g"}, 32'(led_g), color ? 32'(exp_led) : 32'(0));
    check({name, "_step"}, 32'(step), 32'(exp_step));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_in(input logic e, input logic [1:0] s, input logic [1:0] m, input logic c);
    enable = e; speed = s; mode = m; color = c;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    set_in(1'b1, 2'd0, 2'd0, 1'b0);
    @(negedge clock);
    check_outs("reset", 4'h1, 1'b0);
    reset = 1'b0;

    // rotate-left, rotate-right with colour switch, ping-pong with end holds, blink
    vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 3, 4'h1, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 1, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 4, 4'h4, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 4, 4'h8, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 4, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 1, 4'h1, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 2'd1, 1'b0, 1, 4'h1, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 2'd1, 1'b0, 7, 4'h1, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 2'd1, 1'b0, 1, 4'h8, 1'b1});
    vecs.push_back('{1'b1, 2'd1, 2'd1, 1'b0, 8, 4'h4, 1'b1});
    vecs.push_back('{1'b1, 2'd1, 2'd1, 1'b1, 8, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 2'd1, 2'd1, 1'b1, 8, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 1, 4'h1, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 4, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 4, 4'h4, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 4, 4'h8, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 3, 4'h8, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 1, 4'h4, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 4, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 4, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 3, 4'h1, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 2'd2, 1'b0, 1, 4'h2, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd3, 1'b0, 1, 4'hF, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 2'd3, 1'b0, 4, 4'h0, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 2'd3, 1'b0, 4, 4'hF, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].en, vecs[i].spd, vecs[i].md, vecs[i].col);
      #1;
      check_outs($sformatf("vec%0d_pre", i), led, step);
      cycles(vecs[i].cyc);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_step);
    end

    // colour steering follows i_color with no clock edge
    color = 1'b1;
    #1;
    check("color_g_now", 32'(led_g), 32'hF);
    check("color_b_now", 32'(led_b), 32'h0);
    color = 1'b0;

    // enable drop mid-count: state frozen, remaining count resumes
    cycles(2);
    check_outs("blink_cnt2", 4'hF, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      check_outs($sformatf("hold%0d", i), 4'hF, 1'b0);
    end
    enable = 1'b1;
    cycles(1);
    check_outs("resume_cnt3", 4'hF, 1'b0);
    cycles(1);
    check_outs("resume_tick", 4'h0, 1'b1);

    // speed drop below current count ticks at once; mode change beats a tick
    set_in(1'b1, 2'd3, 2'd0, 1'b0);
    cycles(1);
    check_outs("rl_reload", 4'h1, 1'b0);
    cycles(20);
    check_outs("slow_cnt20", 4'h1, 1'b0);
    speed = 2'd0;
    cycles(1);
    check_outs("speed_drop_tick", 4'h2, 1'b1);
    speed = 2'd3;
    cycles(20);
    check_outs("slow_cnt20b", 4'h2, 1'b0);
    set_in(1'b1, 2'd0, 2'd1, 1'b0);
    cycles(1);
    check_outs("reload_beats_tick", 4'h1, 1'b0);
    cycles(3);
    check_outs("after_reload_cnt3", 4'h1, 1'b0);
    cycles(1);
    check_outs("after_reload_tick", 4'h8, 1'b1);

    // asynchronous reset between edges
    repeat (4) @(posedge clock);
    #1;
    check_outs("pre_async", 4'h4, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_outs("async_reset", 4'h1, 1'b0);
    @(negedge clock);
    mode = 2'd0;
    reset = 1'b0;
    cycles(3);
    check_outs("post_reset_cnt3", 4'h1, 1'b0);
    cycles(1);
    check_outs("post_reset_tick", 4'h2, 1'b1);

    // randomized run against the reference model, starting from a reset with a random mode
    @(negedge clock);
    mode = 2'($urandom_range(0, 3));
    reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    check_outs("rand_reset", model_led(), m_step);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      color = 1'($urandom_range(0, 1));
      @(posedge clock);
      model_step();
      @(negedge clock);
      check_outs($sformatf("rand%0d", i), model_led(), m_step);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
